// File: rtl/bus_responder_pkg.sv
// ============================================================================
// Module      : bus_responder_pkg
// Description : Shared bus constants: MMIO map, unmapped-read pattern,
//               responder state encoding and address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  lat_cnt_t;

    localparam logic [3:0] c_mmio_region       = 4'hF;
    localparam word_t      c_mmio_counter_addr = 32'hFFFF_FFF0;
    localparam word_t      c_mmio_scratch_addr = 32'hFFFF_FFF4;
    localparam word_t      c_unmapped_pattern  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_mmio(input word_t addr);
        return addr[31:28] == c_mmio_region;
    endfunction

    // Word-granular address compare; byte-offset bits never distinguish registers.
    function automatic logic word_match(input word_t addr, input word_t reg_addr);
        return (addr | 32'h3) == (reg_addr | 32'h3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_responder_if.sv
// ============================================================================
// Module      : bus_responder_if
// Description : Request/response bus between a master and the responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_responder_if;
    import bus_responder_pkg::*;

    logic  bus_req_ready;
    logic  bus_req_read;
    logic  bus_req_write;
    word_t bus_req_address;
    word_t bus_req_data;
    logic  bus_res_valid;
    word_t bus_res_data;

    modport master (
        input  bus_req_ready,
        output bus_req_read,
        output bus_req_write,
        output bus_req_address,
        output bus_req_data,
        input  bus_res_valid,
        input  bus_res_data
    );

    modport slave (
        output bus_req_ready,
        input  bus_req_read,
        input  bus_req_write,
        input  bus_req_address,
        input  bus_req_data,
        output bus_res_valid,
        output bus_res_data
    );

endinterface

`default_nettype wire

// File: rtl/bus_responder_ram.sv
// ============================================================================
// Module      : bus_responder_ram
// Description : 2^ADDR_BITS x 32 single-clock RAM, one write port and one
//               synchronous read port whose output holds between reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_responder_ram
    import bus_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  word_t                wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output word_t                rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    word_t r_mem [DEPTH];
    word_t r_rdata;

    // The array itself is never reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bus_responder.sv
// ============================================================================
// Module      : bus_responder
// Description : Bus slave with RAM, cycle counter and scratch MMIO; reads
//               answer LATENCY cycles after accept, writes complete at once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic           clock,
    input  logic           reset,
    bus_responder_if.slave bus
);

    state_t   r_state;
    lat_cnt_t r_cnt;
    logic     r_ready;
    logic     r_valid;
    word_t    r_cycle;
    word_t    r_scratch;
    word_t    r_mmio_data;
    logic     r_sel_mmio;

    logic                 w_is_mmio;
    logic                 w_acc_read;
    logic                 w_acc_write;
    logic                 w_ram_we;
    logic                 w_ram_re;
    logic                 w_scratch_we;
    logic [ADDR_BITS-1:0] w_ram_addr;
    word_t                w_mmio_rdata;
    word_t                w_ram_rdata;
    word_t                w_rd_data;

    // Read and write together is a write; a read is only the pure-read case.
    assign w_is_mmio    = is_mmio(bus.bus_req_address);
    assign w_acc_write  = r_ready & bus.bus_req_write;
    assign w_acc_read   = r_ready & bus.bus_req_read & ~bus.bus_req_write;
    assign w_ram_addr   = bus.bus_req_address[ADDR_BITS+1:2];
    assign w_ram_we     = w_acc_write & ~w_is_mmio & ~reset;
    assign w_ram_re     = w_acc_read & ~w_is_mmio & ~reset;
    assign w_scratch_we = w_acc_write & w_is_mmio
                        & word_match(bus.bus_req_address, c_mmio_scratch_addr);

    assign w_mmio_rdata = word_match(bus.bus_req_address, c_mmio_counter_addr) ? r_cycle
                        : word_match(bus.bus_req_address, c_mmio_scratch_addr) ? r_scratch
                        : c_unmapped_pattern;

    assign w_rd_data = r_sel_mmio ? r_mmio_data : w_ram_rdata;

    bus_responder_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clock),
        .rst   (reset),
        .we    (w_ram_we),
        .waddr (w_ram_addr),
        .wdata (bus.bus_req_data),
        .re    (w_ram_re),
        .raddr (w_ram_addr),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_cycle     <= '0;
            r_scratch   <= '0;
            r_mmio_data <= '0;
            r_sel_mmio  <= 1'b1;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_valid <= 1'b0;
            if (w_scratch_we) begin
                r_scratch <= bus.bus_req_data;
            end
            if (w_acc_read) begin
                r_sel_mmio  <= w_is_mmio;
                r_mmio_data <= w_mmio_rdata;
            end
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_acc_read) begin
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= lat_cnt_t'(LATENCY - 1);
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Leave WAIT as the decremented count reaches zero.
                    r_cnt <= r_cnt - lat_cnt_t'(1);
                    if (r_cnt == lat_cnt_t'(1)) begin
                        r_state <= ST_RESP;
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat_one
            // Both sources only change on a read accept, so the mux output
            // already holds its value between responses.
            assign bus.bus_res_data = w_rd_data;
        end else begin : g_lat_multi
            word_t r_res_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_res_data <= '0;
                end else if ((r_state == ST_WAIT) && (r_cnt == lat_cnt_t'(1))) begin
                    r_res_data <= w_rd_data;
                end
            end

            assign bus.bus_res_data = r_res_data;
        end
    endgenerate

    assign bus.bus_req_ready = r_ready;
    assign bus.bus_res_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// ============================================================================
// Module      : tb_bus_responder
// Description : Drives a LATENCY=2 and a LATENCY=1 responder with shared
//               stimulus and checks both against a cycle-indexed model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_responder;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;

    always #5 clk = ~clk;

    bus_responder_if bus0 ();
    bus_responder_if bus1 ();

    assign bus0.bus_req_read    = rd;
    assign bus0.bus_req_write   = wr;
    assign bus0.bus_req_address = addr;
    assign bus0.bus_req_data    = wdata;
    assign bus1.bus_req_read    = rd;
    assign bus1.bus_req_write   = wr;
    assign bus1.bus_req_address = addr;
    assign bus1.bus_req_data    = wdata;

    bus_responder #(.ADDR_BITS(10), .LATENCY(2)) dut0 (.clock(clk), .reset(rst), .bus(bus0));
    bus_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (.clock(clk), .reset(rst), .bus(bus1));

    logic        act_ready [2];
    logic        act_valid [2];
    logic [31:0] act_data  [2];

    assign act_ready[0] = bus0.bus_req_ready;
    assign act_valid[0] = bus0.bus_res_valid;
    assign act_data[0]  = bus0.bus_res_data;
    assign act_ready[1] = bus1.bus_req_ready;
    assign act_valid[1] = bus1.bus_res_valid;
    assign act_data[1]  = bus1.bus_res_data;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Model state: absolute cycle index, per-instance timing and memories.
    longint      cyc = 0;
    bit          armed = 1'b0;
    longint      ready_from [2];
    longint      due        [2];
    logic [31:0] due_data   [2];
    bit          due_known  [2];
    logic [31:0] last       [2];
    bit          last_known [2];
    logic [31:0] scr        [2];
    logic [31:0] m_t        [2];
    logic [31:0] ram        [2][1024];
    bit          known      [2][1024];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void step(input int i);
        logic [31:0] v;
        bit          vk;
        int          idx;
        if (rst) begin
            m_t[i]        = '0;
            ready_from[i] = 0;
            due[i]        = -1;
            last[i]       = '0;
            last_known[i] = 1'b1;
            scr[i]        = '0;
            return;
        end
        if (cyc == due[i]) begin
            last[i]       = due_data[i];
            last_known[i] = due_known[i];
        end
        idx = int'(addr[11:2]);
        if ((cyc >= ready_from[i]) && (rd || wr)) begin
            if (wr) begin
                if (addr[31:28] != 4'hF) begin
                    ram[i][idx]   = wdata;
                    known[i][idx] = 1'b1;
                end else if (addr[31:2] == 30'h3FFF_FFFD) begin
                    scr[i] = wdata;
                end
            end else begin
                vk = 1'b1;
                if (addr[31:28] != 4'hF) begin
                    v  = ram[i][idx];
                    vk = known[i][idx];
                end else if (addr[31:2] == 30'h3FFF_FFFC) begin
                    v = m_t[i];
                end else if (addr[31:2] == 30'h3FFF_FFFD) begin
                    v = scr[i];
                end else begin
                    v = 32'hDEAD_BEEF;
                end
                due[i]        = cyc + lat_of(i);
                ready_from[i] = cyc + lat_of(i);
                due_data[i]   = v;
                due_known[i]  = vk;
            end
        end
        m_t[i] = m_t[i] + 32'd1;
    endfunction

    always @(negedge clk) begin
        bit ev;
        for (int i = 0; i < 2; i++) begin
            if (armed) begin
                ev = (cyc == due[i]);
                check($sformatf("ready%0d", i), 32'(act_ready[i]), 32'(cyc >= ready_from[i]));
                check($sformatf("valid%0d", i), 32'(act_valid[i]), 32'(ev));
                if (ev ? due_known[i] : last_known[i]) begin
                    check($sformatf("data%0d", i), act_data[i], ev ? due_data[i] : last[i]);
                end
            end
            step(i);
        end
        if (rst) armed = 1'b1;
        cyc++;
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Read with hand-computed expectation on both instances.
    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0);
        idle();
        @(negedge clk);
        check({name, "_rdy_low"}, 32'(act_ready[0]), 32'd0);
        check({name, "_v0_early"}, 32'(act_valid[0]), 32'd0);
        check({name, "_v1"}, 32'(act_valid[1]), 32'd1);
        check({name, "_d1"}, act_data[1], exp);
        idle();
        @(negedge clk);
        check({name, "_v0"}, 32'(act_valid[0]), 32'd1);
        check({name, "_d0"}, act_data[0], exp);
        check({name, "_rdy_back"}, 32'(act_ready[0]), 32'd1);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 6))
            0, 1, 2: a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
            3:       a = {4'($urandom_range(0, 14)), 16'($urandom), 6'h0,
                          4'($urandom_range(0, 15)), 2'($urandom)};
            4:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3));
            5:       a = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
            default: a = {4'hF, 28'($urandom)};
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] v1, v2;
        int acc0, acc1, val0, val1;
        int unsigned op;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(act_ready[0]), 32'd1);
        check("rst_valid", 32'(act_valid[0]), 32'd0);
        check("rst_data", act_data[0], 32'h0);
        check("rst_data1", act_data[1], 32'h0);

        // Counter reads equal cycles since reset release.
        idle();
        idle();
        read_check("ctr_after_rst", 32'hFFFF_FFF0, 32'd3);

        drive(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        read_check("ram_rt", 32'h0000_0040, 32'h1234_5678);

        drive(1'b0, 1'b1, 32'h1000_0040, 32'hA5A5_A5A5);
        read_check("alias", 32'h0000_0040, 32'hA5A5_A5A5);

        drive(1'b0, 1'b1, 32'hFFFF_FFF4, 32'hCAFE_F00D);
        read_check("scratch", 32'hFFFF_FFF4, 32'hCAFE_F00D);

        drive(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h1111_1111);
        drive(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        idle();
        drive(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        @(negedge clk);
        v1 = act_data[0];
        check("ctr_not_written", 32'(v1 == 32'h1111_1111), 32'd0);
        idle();
        idle();
        @(negedge clk);
        v2 = act_data[0];
        check("ctr_delta", v2 - v1, 32'd2);

        drive(1'b1, 1'b1, 32'h0000_0080, 32'd7);
        idle();
        @(negedge clk);
        check("rw_no_resp0", 32'(act_valid[0]), 32'd0);
        check("rw_no_resp1", 32'(act_valid[1]), 32'd0);
        idle();
        read_check("rw_is_write", 32'h0000_0080, 32'd7);
        read_check("unmapped", 32'hF000_0000, 32'hDEAD_BEEF);

        idle();
        idle();
        acc0 = 0; acc1 = 0; val0 = 0; val1 = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
            else        idle();
            @(negedge clk);
            if (k < 10) begin
                acc0 += int'(act_ready[0]);
                acc1 += int'(act_ready[1]);
            end
            val0 += int'(act_valid[0]);
            val1 += int'(act_valid[1]);
        end
        check("b2b_acc0", 32'(acc0), 32'd5);
        check("b2b_acc1", 32'(acc1), 32'd10);
        check("b2b_val0", 32'(val0), 32'd5);
        check("b2b_val1", 32'(val1), 32'd10);

        idle();
        drive(1'b0, 1'b1, 32'h0000_0200, 32'h55AA_33CC);
        drive(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        pulse_reset();
        @(negedge clk);
        check("mid_rst_ready", 32'(act_ready[0]), 32'd1);
        check("mid_rst_valid", 32'(act_valid[0]), 32'd0);
        check("mid_rst_data", act_data[0], 32'h0);
        idle();
        @(negedge clk);
        check("mid_rst_no_late", 32'(act_valid[0]), 32'd0);
        read_check("ram_kept", 32'h0000_0200, 32'h55AA_33CC);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                op = $urandom_range(0, 9);
                if (op <= 3)      drive(1'b1, 1'b0, pick_addr(), $urandom);
                else if (op <= 6) drive(1'b0, 1'b1, pick_addr(), $urandom);
                else if (op == 7) drive(1'b1, 1'b1, pick_addr(), $urandom);
                else              idle();
            end
        end
        idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of RAM depth in 32-bit words (1024 words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning read-accept-to-response cycles; legal range is 1..15.
REQ-003 SHALL have port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port bus_req_ready, output, 1, meaning the responder can accept a request this cycle.
REQ-006 SHALL have port bus_req_read, input, 1, meaning a read request.
REQ-007 SHALL have port bus_req_write, input, 1, meaning a write request.
REQ-008 SHALL have port bus_req_address, input, 32, a byte address; bits [1:0] are ignored.
REQ-009 SHALL have port bus_req_data, input, 32, the write data.
REQ-010 SHALL have port bus_res_valid, output, 1, a one-cycle read-response strobe.
REQ-011 SHALL have port bus_res_data, output, 32, the read data, meaningful only while bus_res_valid=1.

Function
REQ-012 SHALL accept a request in a cycle when bus_req_ready=1 and (bus_req_read or bus_req_write)=1.
REQ-013 SHALL treat read and write both asserted as a write only, with no response.
REQ-014 SHALL decode MMIO when address[31:28]=4'hF; otherwise the access is RAM at word index address[ADDR_BITS+1:2], and upper bits alias.
REQ-015 SHALL map MMIO 0xFFFF_FFF0 to a read-only 32-bit cycle counter; writes to it are ignored.
REQ-016 SHALL map MMIO 0xFFFF_FFF4 to a read/write 32-bit scratch register.
REQ-017 SHALL return 0xDEAD_BEEF for reads of any other MMIO address and ignore writes to them.
REQ-018 SHALL complete writes in the accept cycle; writes never produce a response and never deassert bus_req_ready.
REQ-019 SHALL capture read data at accept cycle N, drive bus_res_valid=1 in cycle N+LATENCY for exactly one cycle, and hold bus_res_valid=0 otherwise.
REQ-020 SHALL allow at most one outstanding read.
REQ-021 SHALL hold bus_req_ready=0 in cycles N+1 .. N+LATENCY-1 after a read accepted in cycle N, and SHALL assert it in cycle N+LATENCY, so back-to-back reads are allowed in the response cycle.
REQ-022 SHALL, when a write is accepted in cycle N, return the new data to a read accepted in N+1 (read-after-write).
REQ-023 SHALL run a state machine: IDLE; IDLE --read--> WAIT (down-counter loaded with LATENCY-1); WAIT --counter reaches 0--> RESP; RESP --read--> WAIT; RESP --otherwise--> IDLE.
REQ-024 SHALL, when LATENCY=1, go from IDLE --read--> RESP directly, with bus_req_ready staying 1.
REQ-025 SHALL increment the cycle counter every non-reset cycle, wrapping from 0xFFFF_FFFF to 0; a read returns the value at the accept cycle.
REQ-026 SHALL hold bus_res_data stable while bus_res_valid=0 (last response value, or 0 after reset).

Reset
REQ-027 SHALL, on reset, force state to IDLE, bus_req_ready=1 on the first post-reset cycle, bus_res_valid=0, bus_res_data=0, cycle counter=0 and scratch=0.
REQ-028 SHALL, on reset during WAIT or RESP, drop the pending response; bus_res_valid SHALL be 0 in the cycle after reset is asserted.
REQ-029 SHALL NOT clear RAM contents on reset; RAM writes are suppressed while reset=1.

Structure
REQ-030 SHALL place the MMIO base/addresses (0xF region, 0xFFFF_FFF0, 0xFFFF_FFF4), the 0xDEAD_BEEF pattern and the state encodings in the shared yarvi bus constants package/include, shared with htif.
REQ-031 SHALL use one sub-module bus_responder_ram: single-clock memory, 1 write port and 1 synchronous read port, 2^ADDR_BITS x 32.

Verification
REQ-032 SHALL cover RAM round-trip: write 0x1234_5678 @0x40, then read @0x40 the next cycle -> bus_res_valid exactly 2 cycles after accept with 0x1234_5678; ready low for 1 cycle.
REQ-033 SHALL cover aliasing and scratch: write 0xA5A5_A5A5 @0x1000_0040 then read @0x40 -> 0xA5A5_A5A5; write 0xCAFE_F00D @0xFFFF_FFF4, read back -> 0xCAFE_F00D; write @0xFFFF_FFF0 then read -> counter value, not the written data.
REQ-034 SHALL cover the cycle counter: read 0xFFFF_FFF0 at accept cycle k and k+2 -> values differ by exactly 2; counter value after reset equals cycles since reset release.
REQ-035 SHALL cover back-to-back reads: drive a read continuously -> accepts every 2 cycles, one bus_res_valid per accept, never two outstanding; with LATENCY=1, one accept and one response per cycle.
REQ-036 SHALL cover reset mid-read: read accepted, reset in cycle N+1 -> no bus_res_valid, ready=1 the cycle after reset, and the RAM word previously written is still readable.
REQ-037 SHALL cover illegal/unmapped requests: read+write together @0x80 data 7 -> no response, later read returns 7; read @0xF000_0000 -> 0xDEAD_BEEF.
